// File: rtl/mem_data_resp_if.sv
// Load/store bus between the core (master) and the data-memory responder (slave).
interface mem_data_resp_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_data_resp.sv
// Data-memory responder: one RV32I load/store at a time, fixed wait states,
// byte/half/word access on an internal word array, extended load data back.
module mem_data_resp #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  mem_data_resp_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic [31:0] mem_q [DEPTH];

  logic          err_s;
  logic [AW-1:0] idx_s;
  logic [31:0]   rd_word_s;
  logic [7:0]    lane_byte_s;
  logic [15:0]   lane_half_s;
  logic [31:0]   load_data_s;
  logic          mem_we_s;
  logic [3:0]    mem_be_s;
  logic [31:0]   mem_wdata_s;

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  assign idx_s     = addr_q[AW+1:2];
  assign rd_word_s = mem_q[idx_s];

  // Classify the latched request: illegal encoding, misalignment, out of range.
  always_comb begin
    logic illegal_s, misalign_s, range_s;
    illegal_s  = (funct3_q == 3'b011) || (funct3_q == 3'b110) ||
                 (funct3_q == 3'b111) || (we_q && funct3_q[2]);
    misalign_s = ((funct3_q[1:0] == 2'b01) && addr_q[0]) ||
                 ((funct3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
    range_s    = ({2'b00, addr_q[31:2]} >= 32'(DEPTH));
    err_s      = illegal_s || misalign_s || range_s;
  end

  // Pick the addressed lanes of the read word and extend them per funct3.
  always_comb begin
    case (addr_q[1:0])
      2'b00:   lane_byte_s = rd_word_s[7:0];
      2'b01:   lane_byte_s = rd_word_s[15:8];
      2'b10:   lane_byte_s = rd_word_s[23:16];
      2'b11:   lane_byte_s = rd_word_s[31:24];
      default: lane_byte_s = 8'h00;
    endcase
    if (addr_q[1]) begin
      lane_half_s = rd_word_s[31:16];
    end else begin
      lane_half_s = rd_word_s[15:0];
    end
    case (funct3_q)
      3'b000:  load_data_s = {{24{lane_byte_s[7]}}, lane_byte_s};
      3'b001:  load_data_s = {{16{lane_half_s[15]}}, lane_half_s};
      3'b010:  load_data_s = rd_word_s;
      3'b100:  load_data_s = {24'h000000, lane_byte_s};
      3'b101:  load_data_s = {16'h0000, lane_half_s};
      default: load_data_s = 32'h0000_0000;
    endcase
  end

  // Replicate right-aligned store data onto every lane and build the byte enables.
  always_comb begin
    case (funct3_q[1:0])
      2'b00: begin
        mem_wdata_s = {4{wdata_q[7:0]}};
        mem_be_s    = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        mem_wdata_s = {2{wdata_q[15:0]}};
        if (addr_q[1]) begin
          mem_be_s = 4'b1100;
        end else begin
          mem_be_s = 4'b0011;
        end
      end
      2'b10: begin
        mem_wdata_s = wdata_q;
        mem_be_s    = 4'b1111;
      end
      default: begin
        mem_wdata_s = 32'h0000_0000;
        mem_be_s    = 4'b0000;
      end
    endcase
  end

  // Next-state and output logic. The access happens on the edge that leaves
  // WAIT once the counter is exhausted, so accept-to-response is WAIT_CYCLES+1.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_we_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          we_d        = bus.req_we;
          funct3_d    = bus.req_funct3;
          addr_d      = bus.req_addr;
          wdata_d     = bus.req_wdata;
          cnt_d       = 4'(WAIT_CYCLES);
          req_ready_d = 1'b0;
          state_d     = ST_WAIT;
        end else begin
          req_ready_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          mem_we_s    = we_q && !err_s;
          rsp_valid_d = 1'b1;
          rsp_err_d   = err_s;
          if (err_s || we_q) begin
            rsp_rdata_d = 32'h0000_0000;
          end else begin
            rsp_rdata_d = load_data_s;
          end
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 32'h0000_0000;
          rsp_err_d   = 1'b0;
          req_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cnt_d       = 4'd0;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'h0000_0000;
        rsp_err_d   = 1'b0;
      end
    endcase
  end

  // Control and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= 32'h0000_0000;
      wdata_q     <= 32'h0000_0000;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Byte-enabled array write; contents survive reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we_s && mem_be_s[i]) begin
        mem_q[idx_s][8*i +: 8] <= mem_wdata_s[8*i +: 8];
      end
    end
  end

endmodule
